// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy (pending-write) scoreboard.
// Latency: 1 cycle. Read data and busy flags are registered, with write-first bypass of same-cycle writes.
// Backpressure: none. Every port is accepted every cycle. A port with rd_en=0 holds its last outputs.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   rd_en/rd_addr       NRP read ports; port i uses rd_addr[i*AW +: AW]
//   rd_data/rd_busy     registered per-port read data [i*XLEN +: XLEN] and busy flag
//   wr_en/wr_addr/wr_data  NWP write ports, packed like the read ports
//   rsv_en/rsv_addr     reserve strobe; marks a register as pending
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP-1:0]      rd_en,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic [AW-1:0]   ra [NRP];
  logic [AW-1:0]   wa [NWP];
  logic [XLEN-1:0] rd_val [NRP];
  logic [NRP-1:0]  rd_bsy;

  // Register 0 and out-of-range addresses are inert: they never store data
  // and never become busy.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  for (genvar i = 0; i < NRP; i++) begin : g_ra
    assign ra[i] = rd_addr[i*AW +: AW];
  end
  for (genvar j = 0; j < NWP; j++) begin : g_wa
    assign wa[j] = wr_addr[j*AW +: AW];
  end

  // Post-edge busy state: writes clear, then the reserve sets, so a reserve
  // and a write to the same register in one cycle leave it busy.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWP; j++) begin
      if (wr_en[j] && addr_ok(wa[j])) begin
        busy_nxt[wa[j]] = 1'b0;
      end
    end
    if (rsv_en && addr_ok(rsv_addr)) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
  end

  // Read value with write-first bypass. Ports are scanned in ascending order
  // so the highest-index matching writer wins, matching the storage update.
  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      rd_val[i] = '0;
      rd_bsy[i] = 1'b0;
      if (addr_ok(ra[i])) begin
        rd_val[i] = mem[ra[i]];
        for (int j = 0; j < NWP; j++) begin
          if (wr_en[j] && (wa[j] == ra[i])) begin
            rd_val[i] = wr_data[j*XLEN +: XLEN];
          end
        end
        rd_bsy[i] = busy_nxt[ra[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        mem[k] <= '0;
      end
      busy    <= '0;
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      // Later non-blocking assignments override earlier ones, so the
      // highest-index port wins on a same-address collision.
      for (int j = 0; j < NWP; j++) begin
        if (wr_en[j] && addr_ok(wa[j])) begin
          mem[wa[j]] <= wr_data[j*XLEN +: XLEN];
        end
      end
      busy <= busy_nxt;
      for (int i = 0; i < NRP; i++) begin
        if (rd_en[i]) begin
          rd_data[i*XLEN +: XLEN] <= rd_val[i];
          rd_busy[i]              <= rd_bsy[i];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register width in bits.
REQ-002 SHALL provide parameter NREG, default 32, number of architectural registers (>=2).
REQ-003 SHALL provide parameter NRP, default 2, number of read ports (>=1).
REQ-004 SHALL provide parameter NWP, default 1, number of write ports (>=1).
REQ-005 SHALL derive AW = ceil(log2(NREG)) as the address width; AW is not user-overridable.
REQ-006 Ports (name  direction  width  meaning), listed in REQ-007 to REQ-017.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 rd_en  in  NRP  per-port read enable.
REQ-010 rd_addr  in  NRP*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-011 rd_data  out  NRP*XLEN  registered read data; port i at [i*XLEN +: XLEN].
REQ-012 rd_busy  out  NRP  registered scoreboard-busy flag of the register read on port i.
REQ-013 wr_en  in  NWP  per-port write enable.
REQ-014 wr_addr  in  NWP*AW  write addresses, packed as rd_addr.
REQ-015 wr_data  in  NWP*XLEN  write data, packed as rd_data.
REQ-016 rsv_en  in  1  reserve strobe: mark rsv_addr as pending.
REQ-017 rsv_addr  in  AW  register to reserve.

Function
REQ-018 SHALL hold NREG x XLEN storage plus one busy bit per register.
REQ-019 Register 0 SHALL read as 0 and never be busy; writes and reserves to it are ignored.
REQ-020 Addresses >= NREG: reads return 0 with busy 0; writes and reserves are ignored.
REQ-021 Write: at the edge with wr_en[j]=1, mem[wr_addr[j]] <= wr_data[j]; all enabled ports commit in the same cycle.
REQ-022 Same-address writes from several ports in one cycle: the highest-index port wins.
REQ-023 Read latency SHALL be 1 cycle: with rd_en[i]=1 at edge N, rd_data[i] shows the value from edge N onward.
REQ-024 With rd_en[i]=0, rd_data[i] and rd_busy[i] SHALL hold their previous values.
REQ-025 Write-first bypass: a same-cycle write to rd_addr[i] SHALL be returned on rd_data[i], using the winning port's data per REQ-022.
REQ-026 Any number of read ports SHALL be able to read the same address in one cycle.
REQ-027 Scoreboard: rsv_en=1 sets busy[rsv_addr]; a write to an address clears its busy bit.
REQ-028 Reserve and write to the same address in one cycle: the data is written and busy ends at 1 (reserve wins).
REQ-029 rd_busy[i] SHALL capture the post-edge busy value of rd_addr[i] (bypassed, consistent with REQ-025 and REQ-028).
REQ-030 Reserving an already-busy register SHALL leave it busy; writing a non-busy register SHALL leave busy at 0.
REQ-031 No combinational path SHALL exist from any input to any output.

Reset
REQ-032 rst=1 at an edge SHALL clear all storage, all busy bits, rd_data and rd_busy to 0.
REQ-033 Reset SHALL override any write, reserve or read presented in the same cycle.
REQ-034 Reset asserted mid-operation SHALL discard that cycle's inputs; normal operation resumes at the first edge with rst=0.

Verification
REQ-035 Reset, then read x0..x31 on all ports -> every rd_data=0 and rd_busy=0.
REQ-036 Write x5=0xDEADBEEF and read x5 on port 0 in the same cycle -> next cycle rd_data[0]=0xDEADBEEF (bypass); write x0=0x1234 then read x0 -> 0.
REQ-037 NWP=2: port0 writes x7=0x11 and port1 writes x7=0x22 together -> subsequent read of x7 returns 0x22.
REQ-038 Reserve x9 -> read x9 gives rd_busy=1; write x9=0x55 with a simultaneous read -> rd_data=0x55, rd_busy=0; reserve and write x9 in one cycle -> rd_busy=1.
REQ-039 Write x3=0xA5 with rst=1 in the same cycle -> x3 reads 0 after reset deasserts; rd_en held 0 across cycles -> rd_data unchanged.
